// File: rtl/rfblackwidow_cvalid_seq_if.sv
// Fill / invalidate / lookup bundle for the cache valid-bit store.
// master = cache controller side, slave = the valid-bit store.
interface rfblackwidow_cvalid_seq_if #(
    parameter int WAYS = 4,
    parameter int AWID = 32
);
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic            wr;
    logic [WW-1:0]   wr_way;
    logic [AWID-1:0] wr_adr;
    logic            wr_rdy;

    logic            inv_req;
    logic [1:0]      inv_mode;
    logic [AWID-1:0] inv_adr;
    logic [WW-1:0]   inv_way;
    logic            inv_rdy;
    logic            busy;
    logic            inv_done;

    logic [AWID-1:0] rd_adr;
    logic [WAYS-1:0] valid_o;
    logic [WW-1:0]   victim;

    modport master (
        output wr, wr_way, wr_adr, inv_req, inv_mode, inv_adr, inv_way, rd_adr,
        input  wr_rdy, inv_rdy, busy, inv_done, valid_o, victim
    );

    modport slave (
        input  wr, wr_way, wr_adr, inv_req, inv_mode, inv_adr, inv_way, rd_adr,
        output wr_rdy, inv_rdy, busy, inv_done, valid_o, victim
    );
endinterface

// File: rtl/rfblackwidow_cvalid_seq.sv
// Cache valid-bit array with per-line/per-way invalidate and a one-set-per-cycle invalidate-all sweep.
// Lookup result registered one cycle after rd_adr; wr/inv are refused (rdy low) for the LINES-cycle sweep.
module rfblackwidow_cvalid_seq #(
    parameter int LINES = 128,
    parameter int WAYS  = 4,
    parameter int OFFS  = 7,
    parameter int AWID  = 32
) (
    input  logic clk,
    input  logic rst,
    rfblackwidow_cvalid_seq_if.slave bus
);
    localparam int IW = $clog2(LINES);
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_sweep;
    logic [WW-1:0]   r_rr;
    logic [WAYS-1:0] r_arr [LINES] = '{default: '0};
    logic [WAYS-1:0] r_valid;
    logic [WW-1:0]   r_victim;
    logic            r_done;

    logic            w_busy;
    logic            w_sweep_last;
    logic            w_wr_acc;
    logic            w_inv_acc;
    logic            w_inv_line;
    logic [IW-1:0]   w_wr_idx;
    logic [IW-1:0]   w_inv_idx;
    logic [IW-1:0]   w_rd_idx;
    logic [WAYS-1:0] w_wr_oh;
    logic [WAYS-1:0] w_inv_mask;
    logic [WAYS-1:0] w_rd_set;
    logic [WW-1:0]   w_victim;
    logic            w_unused;

    assign w_wr_idx  = bus.wr_adr[OFFS +: IW];
    assign w_inv_idx = bus.inv_adr[OFFS +: IW];
    assign w_rd_idx  = bus.rd_adr[OFFS +: IW];
    assign w_unused  = ^{bus.wr_adr, bus.inv_adr, bus.rd_adr};

    assign w_wr_acc   = bus.wr & ~w_busy;
    assign w_inv_acc  = bus.inv_req & ~w_busy;
    assign w_inv_line = w_inv_acc & ~bus.inv_mode[1];

    // With a single way the way fields carry no information.
    assign w_wr_oh    = (WAYS == 1) ? WAYS'(1) : (WAYS'(1) << bus.wr_way);
    assign w_inv_mask = (bus.inv_mode == 2'd0) ? '1 :
                        ((WAYS == 1) ? WAYS'(1) : (WAYS'(1) << bus.inv_way));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_inv_acc && bus.inv_mode == 2'd2) w_state_nxt = SWEEP;
            SWEEP:   if (w_sweep_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy       = (r_state == SWEEP);
        w_sweep_last = (r_state == SWEEP) && (r_sweep == IW'(LINES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst || r_state != SWEEP) r_sweep <= '0;
        else                         r_sweep <= r_sweep + IW'(1);
    end

    // The sweep only runs while requests are refused, so it never races a fill.
    always_ff @(posedge clk) begin
        for (int s = 0; s < LINES; s++) begin
            if (rst || (w_busy && r_sweep == IW'(s))) begin
                r_arr[s] <= '0;
            end else if ((w_wr_acc && w_wr_idx == IW'(s)) ||
                         (w_inv_line && w_inv_idx == IW'(s))) begin
                r_arr[s] <= (r_arr[s] | ((w_wr_acc && w_wr_idx == IW'(s)) ? w_wr_oh : '0))
                          & ~((w_inv_line && w_inv_idx == IW'(s)) ? w_inv_mask : '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)           r_rr <= '0;
        else if (w_wr_acc) r_rr <= (WAYS == 1) ? '0 : r_rr + WW'(1);
    end

    assign w_rd_set = r_arr[w_rd_idx];

    always_comb begin
        w_victim = r_rr;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!w_rd_set[i]) w_victim = WW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_victim <= '0;
            r_done   <= 1'b0;
        end else begin
            r_valid  <= w_busy ? '0 : w_rd_set;
            r_victim <= w_victim;
            r_done   <= (w_inv_acc && bus.inv_mode != 2'd2) || w_sweep_last;
        end
    end

    assign bus.wr_rdy   = ~w_busy;
    assign bus.inv_rdy  = ~w_busy;
    assign bus.busy     = w_busy;
    assign bus.inv_done = r_done;
    // Masking covers the acceptance cycle, whose registered lookup predates the sweep.
    assign bus.valid_o  = r_valid & {WAYS{~w_busy}};
    assign bus.victim   = r_victim;
endmodule

// File: tb/tb_rfblackwidow_cvalid_seq.sv
// Scoreboard bench for the cache valid-bit array: fills, line/way/all invalidates, sweep and reset abort.
module tb_rfblackwidow_cvalid_seq;
    localparam int LINES = 128;
    localparam int WAYS  = 4;
    localparam int OFFS  = 7;
    localparam int AWID  = 32;

    typedef struct packed {
        logic [3:0] vld;
        logic [1:0] vic;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rfblackwidow_cvalid_seq_if #(.WAYS(WAYS), .AWID(AWID)) ifc ();

    rfblackwidow_cvalid_seq #(.LINES(LINES), .WAYS(WAYS), .OFFS(OFFS), .AWID(AWID)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int   checks = 0;
    int   errors = 0;
    logic [3:0] m_arr [LINES];
    logic [1:0] m_rr;
    exp_t sb_q[$];

    function automatic logic [31:0] adr_of(int set);
        return 32'(set) << OFFS;
    endfunction

    function automatic exp_t model_lookup(int set);
        exp_t e;
        e.vld = m_arr[set];
        e.vic = m_rr;
        for (int i = 3; i >= 0; i--) if (!m_arr[set][i]) e.vic = 2'(i);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int s = 0; s < LINES; s++) m_arr[s] = '0;
        m_rr = '0;
    endtask

    task automatic fill(int way, int set);
        ifc.wr = 1'b1; ifc.wr_way = 2'(way); ifc.wr_adr = adr_of(set);
        tick();
        ifc.wr = 1'b0;
        m_arr[set][way] = 1'b1;
        m_rr = m_rr + 2'd1;
    endtask

    task automatic inv(int mode, int set, int way);
        ifc.inv_req = 1'b1; ifc.inv_mode = 2'(mode); ifc.inv_adr = adr_of(set); ifc.inv_way = 2'(way);
        tick();
        ifc.inv_req = 1'b0;
        if (mode == 0) m_arr[set] = '0;
        if (mode == 1) m_arr[set][way] = 1'b0;
    endtask

    task automatic lookup(int set);
        ifc.rd_adr = adr_of(set);
        sb_q.push_back(model_lookup(set));
        tick();
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_clear();
        checks++; if (ifc.valid_o !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b exp 0000", ifc.valid_o); end
        checks++; if (ifc.victim !== 2'd0) begin errors++; $display("FAIL reset_victim got %0d exp 0", ifc.victim); end
        checks++; if ({ifc.busy, ifc.inv_done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b exp 00", {ifc.busy, ifc.inv_done}); end
        checks++; if ({ifc.wr_rdy, ifc.inv_rdy} !== 2'b11) begin errors++; $display("FAIL reset_rdy got %b exp 11", {ifc.wr_rdy, ifc.inv_rdy}); end
        lookup(3);
        e = sb_q.pop_front();
        checks++; if ({ifc.valid_o, ifc.victim} !== e) begin errors++; $display("FAIL reset_lookup got %b/%0d exp %b/%0d", ifc.valid_o, ifc.victim, e.vld, e.vic); end
    endtask

    task automatic test_fill_lookup();
        exp_t e;
        fill(2, 3);
        lookup(3);
        e = sb_q.pop_front();
        checks++; if ({ifc.valid_o, ifc.victim} !== {4'b0100, 2'd0}) begin errors++; $display("FAIL fill_set3 got %b/%0d exp 0100/0", ifc.valid_o, ifc.victim); end
        checks++; if ({ifc.valid_o, ifc.victim} !== e) begin errors++; $display("FAIL fill_set3_sb got %b/%0d exp %b/%0d", ifc.valid_o, ifc.victim, e.vld, e.vic); end
    endtask

    task automatic test_inv_way();
        exp_t e;
        fill(0, 3); fill(1, 3); fill(3, 3);
        lookup(3);
        e = sb_q.pop_front();
        checks++; if ({ifc.valid_o, ifc.victim} !== {4'b1111, 2'd0}) begin errors++; $display("FAIL full_set3 got %b/%0d exp 1111/0", ifc.valid_o, ifc.victim); end
        checks++; if ({ifc.valid_o, ifc.victim} !== e) begin errors++; $display("FAIL full_set3_sb got %b/%0d exp %b/%0d", ifc.valid_o, ifc.victim, e.vld, e.vic); end
        inv(1, 3, 1);
        checks++; if (ifc.inv_done !== 1'b1) begin errors++; $display("FAIL mode1_done got %b exp 1", ifc.inv_done); end
        tick();
        checks++; if (ifc.inv_done !== 1'b0) begin errors++; $display("FAIL mode1_done_width got %b exp 0", ifc.inv_done); end
        lookup(3);
        e = sb_q.pop_front();
        checks++; if ({ifc.valid_o, ifc.victim} !== {4'b1101, 2'd1}) begin errors++; $display("FAIL mode1_set3 got %b/%0d exp 1101/1", ifc.valid_o, ifc.victim); end
        inv(3, 3, 0);
        checks++; if (ifc.inv_done !== 1'b1) begin errors++; $display("FAIL mode3_done got %b exp 1", ifc.inv_done); end
        lookup(3);
        e = sb_q.pop_front();
        checks++; if ({ifc.valid_o, ifc.victim} !== e) begin errors++; $display("FAIL mode3_noop got %b/%0d exp %b/%0d", ifc.valid_o, ifc.victim, e.vld, e.vic); end
    endtask

    task automatic test_same_cycle();
        exp_t e;
        ifc.wr = 1'b1; ifc.wr_way = 2'd0; ifc.wr_adr = adr_of(5);
        inv(0, 5, 0);
        ifc.wr = 1'b0;
        m_rr = m_rr + 2'd1;
        ifc.wr = 1'b1; ifc.wr_way = 2'd0; ifc.wr_adr = adr_of(6);
        inv(0, 5, 0);
        ifc.wr = 1'b0;
        m_arr[6][0] = 1'b1;
        m_rr = m_rr + 2'd1;
        lookup(5);
        e = sb_q.pop_front();
        checks++; if (ifc.valid_o !== 4'b0000 || {ifc.valid_o, ifc.victim} !== e) begin errors++; $display("FAIL same_set_way got %b/%0d exp 0000/%0d", ifc.valid_o, ifc.victim, e.vic); end
        lookup(6);
        e = sb_q.pop_front();
        checks++; if (ifc.valid_o !== 4'b0001 || {ifc.valid_o, ifc.victim} !== e) begin errors++; $display("FAIL diff_set got %b/%0d exp 0001/%0d", ifc.valid_o, ifc.victim, e.vic); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   sets [6] = '{20, 21, 22, 30, 31, 3};
        fill(1, 20); fill(0, 21); fill(3, 21); fill(2, 22);
        fill(0, 30); fill(1, 30); fill(2, 30); fill(3, 30); fill(1, 31);
        for (int i = 0; i < 6; i++) begin
            lookup(sets[i]);
            e = sb_q.pop_front();
            checks++; if ({ifc.valid_o, ifc.victim} !== e) begin errors++; $display("FAIL b2b_set%0d got %b/%0d exp %b/%0d", sets[i], ifc.valid_o, ifc.victim, e.vld, e.vic); end
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        int   cnt = 0, done_cnt = 0, rdy_bad = 0, vld_bad = 0;
        int   sets [4] = '{0, 5, 30, 127};
        fill(0, 0); fill(3, 127);
        ifc.rd_adr = adr_of(127);
        ifc.wr = 1'b1; ifc.wr_way = 2'd1; ifc.wr_adr = adr_of(40);
        inv(2, 0, 0);
        ifc.wr_way = 2'd2; ifc.wr_adr = adr_of(41);
        while (ifc.busy === 1'b1 && cnt < 300) begin
            cnt++;
            if (ifc.wr_rdy !== 1'b0 || ifc.inv_rdy !== 1'b0) rdy_bad++;
            if (ifc.valid_o !== 4'b0000) vld_bad++;
            if (ifc.inv_done === 1'b1) done_cnt++;
            tick();
        end
        ifc.wr = 1'b0;
        model_clear();
        m_rr = 2'(m_rr + 0);
        checks++; if (cnt !== 128) begin errors++; $display("FAIL sweep_len got %0d exp 128", cnt); end
        checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL sweep_rdy got %0d bad cycles exp 0", rdy_bad); end
        checks++; if (vld_bad !== 0) begin errors++; $display("FAIL sweep_valid got %0d bad cycles exp 0", vld_bad); end
        checks++; if (done_cnt !== 0 || ifc.inv_done !== 1'b1) begin errors++; $display("FAIL sweep_done got %0d early, final %b exp 0, 1", done_cnt, ifc.inv_done); end
        tick();
        checks++; if (ifc.inv_done !== 1'b0) begin errors++; $display("FAIL sweep_done_width got %b exp 0", ifc.inv_done); end
        for (int i = 0; i < 4; i++) begin
            lookup(sets[i]);
            e = sb_q.pop_front();
            checks++; if ({ifc.valid_o, ifc.victim} !== e) begin errors++; $display("FAIL post_sweep_set%0d got %b/%0d exp %b/%0d", sets[i], ifc.valid_o, ifc.victim, e.vld, e.vic); end
        end
        lookup(40);
        e = sb_q.pop_front();
        checks++; if (ifc.valid_o !== 4'b0000) begin errors++; $display("FAIL sweep_clears_wr got %b exp 0000", ifc.valid_o); end
    endtask

    task automatic test_reset_mid_sweep();
        exp_t e;
        int   done_seen = 0;
        fill(2, 100); fill(1, 10);
        inv(2, 0, 0);
        for (int i = 0; i < 40; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        checks++; if (ifc.busy !== 1'b0 || ifc.wr_rdy !== 1'b1) begin errors++; $display("FAIL rst_abort_busy got busy %b rdy %b exp 0 1", ifc.busy, ifc.wr_rdy); end
        if (ifc.inv_done === 1'b1) done_seen++;
        fill(1, 7);
        for (int i = 0; i < 100; i++) begin
            if (ifc.inv_done === 1'b1) done_seen++;
            tick();
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL rst_abort_done got %0d pulses exp 0", done_seen); end
        lookup(7);
        e = sb_q.pop_front();
        checks++; if ({ifc.valid_o, ifc.victim} !== {4'b0010, 2'd0} || {ifc.valid_o, ifc.victim} !== e) begin errors++; $display("FAIL rst_wr_set7 got %b/%0d exp 0010/0", ifc.valid_o, ifc.victim); end
        lookup(100);
        e = sb_q.pop_front();
        checks++; if ({ifc.valid_o, ifc.victim} !== e) begin errors++; $display("FAIL rst_cleared_set100 got %b/%0d exp %b/%0d", ifc.valid_o, ifc.victim, e.vld, e.vic); end
    endtask

    initial begin
        rst = 1'b1;
        ifc.wr = 1'b0; ifc.wr_way = '0; ifc.wr_adr = '0;
        ifc.inv_req = 1'b0; ifc.inv_mode = '0; ifc.inv_adr = '0; ifc.inv_way = '0;
        ifc.rd_adr = '0;
        model_clear();
        test_reset();
        test_fill_lookup();
        test_inv_way();
        test_same_cycle();
        test_back_to_back();
        test_sweep();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
